// File: rtl/mgt_01_mp_reg_file.sv
// Multi-ported register file with a per-register busy scoreboard.
// After reset, a sweep zeroes every entry; only then does the file accept writes and reserves.
module mgt_01_mp_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clk_en_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [AW-1:0]            rsv_addr_i,
    output logic                     ready_o
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                clr_we;
    logic                run_we;
    logic [NUM_WR-1:0]   wr_act;
    logic                rsv_act;

    // Address 0 is a sink for writes and reserves when it is the hardwired zero register.
    function automatic logic addr_writable(input logic [AW-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR && clk_en_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NUM_REGS - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_o = (state_q == ST_RUN);
        clr_we  = (state_q == ST_CLEAR) && clk_en_i;
        run_we  = (state_q == ST_RUN) && clk_en_i;
    end

    always_comb begin
        wr_act = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_act[k] = run_we && wr_en_i[k] && addr_writable(wr_addr_i[k*AW +: AW]);
        end
        rsv_act = run_we && rsv_en_i && addr_writable(rsv_addr_i);
    end

    // ---------------- register storage ----------------
    // Data has no reset; the clear sweep zeroes it. Higher write ports are applied last and win.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            regs_q[cnt_q] <= '0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_act[k]) begin
                regs_q[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- busy scoreboard ----------------
    // Reserve is applied after the write clears so that a same-cycle reserve keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_we) begin
            busy_d[cnt_q] = 1'b0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_act[k]) begin
                busy_d[wr_addr_i[k*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_act) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            logic [AW-1:0]     ra;
            logic [DATA_W-1:0] rdat;
            logic              rbsy;
            logic              hit;
            ra   = rd_addr_i[j*AW +: AW];
            rdat = regs_q[ra];
            rbsy = busy_q[ra];
            hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_act[k] && (wr_addr_i[k*AW +: AW] == ra)) begin
                        rdat = wr_data_i[k*DATA_W +: DATA_W];
                        rbsy = 1'b0;
                        hit  = 1'b1;
                    end
                end
                if (hit && rsv_act && (rsv_addr_i == ra)) begin
                    rbsy = 1'b1;
                end
            end
            if (!addr_writable(ra) || state_q != ST_RUN) begin
                rdat = '0;
                rbsy = 1'b0;
            end
            rd_data_o[j*DATA_W +: DATA_W] = rdat;
            rd_busy_o[j]                  = rbsy;
        end
    end

endmodule

// File: tb/tb_mgt_01_mp_reg_file.sv
// Directed bench for mgt_01_mp_reg_file: one bypassing and one non-bypassing instance share all inputs.
module tb_mgt_01_mp_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        ready_b, ready_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mgt_01_mp_reg_file #(.BYPASS(1)) u_byp (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready_b)
    );

    mgt_01_mp_reg_file #(.BYPASS(0)) u_nob (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
    endtask

    initial begin
        logic [31:0] acc;
        logic [31:0] bacc;
        rst_n    = 1'b0;
        clk_en   = 1'b1;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        tick();
        tick();
        chk("reset_ready", {30'd0, ready_b, ready_n}, 32'd0);
        chk("reset_rd", rd_data_n[31:0] | rd_data_b[63:32], 32'd0);

        // Initial sweep: 32 enabled edges
        rst_n = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        #2 chk("sweep_ready_31", {31'd0, ready_n}, 32'd0);
        tick();
        #2 chk("sweep_ready_32", {30'd0, ready_b, ready_n}, 32'd3);
        acc  = '0;
        bacc = '0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #0.1;
            acc  = acc | rd_data_n[31:0] | rd_data_n[63:32] | rd_data_b[31:0] | rd_data_b[63:32];
            bacc = bacc | {28'd0, rd_busy_n, rd_busy_b};
        end
        chk("sweep_all_zero", acc, 32'd0);
        chk("sweep_busy_zero", bacc, 32'd0);
        tick();

        // Write reg5 with same-cycle read
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'd0, 32'hDEADBEEF};
        rd_addr = {5'd0, 5'd5};
        #2;
        chk("byp_same_cycle", rd_data_b[31:0], 32'hDEADBEEF);
        chk("nob_same_cycle", rd_data_n[31:0], 32'h0);
        tick();
        idle();
        #2 chk("nob_next_cycle", rd_data_n[31:0], 32'hDEADBEEF);
        tick();

        // Both ports to reg7: port 1 wins
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h22, 32'h11};
        rd_addr = {5'd7, 5'd5};
        #2 chk("byp_dual_write", rd_data_b[63:32], 32'h22);
        tick();
        idle();
        #2 chk("dual_write_reg7", rd_data_n[63:32], 32'h22);
        chk("dual_write_reg7_b", rd_data_b[63:32], 32'h22);
        tick();

        // Reserve reg9
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        rd_addr  = {5'd7, 5'd9};
        #2 chk("rsv_pre_edge", {31'd0, rd_busy_n[0]}, 32'd0);
        tick();
        idle();
        #2 chk("rsv_busy", {30'd0, rd_busy_b[0], rd_busy_n[0]}, 32'd3);
        tick();
        // Write plus reserve on reg9: reserve wins on busy, data stored
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd9};
        wr_data  = {32'd0, 32'h0000A5A5};
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        #2;
        chk("byp_wr_rsv_busy", {31'd0, rd_busy_b[0]}, 32'd1);
        chk("byp_wr_rsv_data", rd_data_b[31:0], 32'h0000A5A5);
        tick();
        idle();
        #2;
        chk("wr_rsv_busy", {31'd0, rd_busy_n[0]}, 32'd1);
        chk("wr_rsv_data", rd_data_n[31:0], 32'h0000A5A5);
        tick();
        // Write alone clears busy
        wr_en   = 2'b01;
        wr_data = {32'd0, 32'h0000005A};
        #2 chk("byp_wr_busy_clr", {31'd0, rd_busy_b[0]}, 32'd0);
        tick();
        idle();
        #2;
        chk("wr_busy_clr", {31'd0, rd_busy_n[0]}, 32'd0);
        chk("wr_clr_data", rd_data_n[31:0], 32'h0000005A);
        tick();

        // Address 0 is hardwired
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd0};
        wr_data  = {32'd0, 32'hFFFFFFFF};
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        rd_addr  = {5'd0, 5'd0};
        #2 chk("byp_zero_reg", {rd_data_b[31:1], rd_busy_b[0] | rd_data_b[0]}, 32'd0);
        tick();
        idle();
        #2;
        chk("zero_reg_data", rd_data_n[31:0] | rd_data_b[31:0], 32'd0);
        chk("zero_reg_busy", {30'd0, rd_busy_n[0], rd_busy_b[0]}, 32'd0);
        tick();

        // clk_en low in RUN holds registers
        clk_en  = 1'b0;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {32'd0, 32'h12345678};
        rd_addr = {5'd7, 5'd4};
        tick();
        idle();
        clk_en = 1'b1;
        #2 chk("hold_no_write", rd_data_n[31:0], 32'd0);
        tick();

        // Reset in RUN: immediate effect
        rsv_en   = 1'b1;
        rsv_addr = 5'd12;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("run_reset_ready", {30'd0, ready_b, ready_n}, 32'd0);
        chk("run_reset_rd7", rd_data_n[63:32] | rd_data_b[63:32], 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        // Counter now at 10; reset mid-sweep and restart with clk_en toggling
        rst_n = 1'b0;
        #1 chk("sweep_reset_ready", {31'd0, ready_n}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 63; i++) begin
            clk_en = (i % 2 == 0);
            if (i >= 40 && i < 46) begin
                wr_en    = 2'b01;
                wr_addr  = {5'd0, 5'd3};
                wr_data  = {32'd0, 32'h00001234};
                rsv_en   = 1'b1;
                rsv_addr = 5'd3;
            end else begin
                idle();
            end
            if (i == 20) begin
                #2 chk("clear_rd_forced0", rd_data_n[63:32], 32'd0);
            end
            if (i == 62) begin
                #2 chk("toggle_ready_31", {31'd0, ready_n}, 32'd0);
            end
            tick();
        end
        idle();
        clk_en = 1'b1;
        #2 chk("toggle_ready_32", {30'd0, ready_b, ready_n}, 32'd3);
        rd_addr = {5'd7, 5'd3};
        #1;
        chk("clear_ignored_wr", rd_data_n[31:0], 32'd0);
        chk("clear_ignored_rsv", {31'd0, rd_busy_n[0]}, 32'd0);
        chk("resweep_reg7", rd_data_n[63:32], 32'd0);
        rd_addr = {5'd12, 5'd5};
        #1;
        chk("resweep_reg5", rd_data_n[31:0], 32'd0);
        chk("resweep_busy12", {31'd0, rd_busy_n[1]}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
